// File: rtl/bit_serializer_if.sv
// Parallel-word in / serial-bit out handshake bundle for bit_serializer.
interface bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_done;

    // Word producer / bit consumer side
    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  sout,
        input  sout_valid,
        input  frame_done
    );

    // Serializer side
    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output sout,
        output sout_valid,
        output frame_done
    );
endinterface

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with zero-gap back-to-back framing.
// Optional feature macro: SER_PARITY_EN appends one even-parity bit per frame.
// WIDTH legal range is 2..32; the interface instance must use the same WIDTH.
module bit_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    bit_serializer_if.slave ser_if
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef SER_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_e;

    state_e           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [WIDTH-1:0] shreg_q,      shreg_d;
    logic             sout_q,       sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             frame_done_q, frame_done_d;
`ifdef SER_PARITY_EN
    logic             parity_q,     parity_d;
`endif

    logic transfer;
    logic load;

    // Ready in IDLE or while the final frame bit is on the wire; forced low in reset
    assign ser_if.din_ready  = rst & ((state_q == IDLE) | frame_done_q);
    assign ser_if.sout       = sout_q;
    assign ser_if.sout_valid = sout_valid_q;
    assign ser_if.frame_done = frame_done_q;

    assign transfer = ser_if.din_valid & ser_if.din_ready;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            frame_done_q <= frame_done_d;
`ifdef SER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Next-state logic; sout_d always holds the bit to show in the following cycle
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        frame_done_d = 1'b0;
        load         = 1'b0;
`ifdef SER_PARITY_EN
        parity_d     = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_IDX) begin
`ifdef SER_PARITY_EN
                    state_d      = PARITY;
                    sout_d       = parity_q;
                    sout_valid_d = 1'b1;
                    frame_done_d = 1'b1;
`else
                    if (transfer) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end else begin
                    // Rotate keeps the captured word intact; next bit sits just below the MSB
                    cnt_d        = cnt_q + CNT_W'(1);
                    shreg_d      = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
                    sout_d       = shreg_q[WIDTH-2];
                    sout_valid_d = 1'b1;
`ifndef SER_PARITY_EN
                    frame_done_d = (cnt_d == LAST_IDX);
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (transfer) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Word capture shared by every accepting state; counter restarts at 0
        if (load) begin
            state_d      = SHIFT;
            cnt_d        = '0;
            shreg_d      = ser_if.din;
            sout_d       = ser_if.din[WIDTH-1];
            sout_valid_d = 1'b1;
            frame_done_d = 1'b0;
`ifdef SER_PARITY_EN
            parity_d     = ^ser_if.din;
`endif
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed and random word streams
// compared against a queue-based frame model.
module tb_bit_serializer;
    localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
    localparam int unsigned FLEN = W + 1;
`else
    localparam int unsigned FLEN = W;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] words_q[$];
    bit           exp_q[$];

    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(W)) sif ();

    bit_serializer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .ser_if (sif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame model: data bits MSB first, then optional even-parity bit
    function automatic void push_frame(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef SER_PARITY_EN
        exp_q.push_back(bit'($countones(w) % 2));
`endif
    endfunction

    task automatic idle_checks(input string tag);
        chk({tag, "_sout"},       32'(sif.sout),       32'd0);
        chk({tag, "_sout_valid"}, 32'(sif.sout_valid), 32'd0);
        chk({tag, "_frame_done"}, 32'(sif.frame_done), 32'd0);
        chk({tag, "_din_ready"},  32'(sif.din_ready),  32'd1);
    endtask

    // Streams words_q back-to-back; mid-frame din is junk and din_valid is random
    task automatic run_stream(input bit rand_junk, input logic [W-1:0] junk);
        logic [W-1:0] got;
        int           nf;
        int           pos;
        bit           last;
        exp_q.delete();
        foreach (words_q[i]) push_frame(words_q[i]);
        chk("pre_ready", 32'(sif.din_ready),  32'd1);
        chk("pre_valid", 32'(sif.sout_valid), 32'd0);
        sif.din       = words_q[0];
        sif.din_valid = 1'b1;
        tick();
        nf  = 1;
        got = '0;
        for (int k = 0; k < exp_q.size(); k++) begin
            pos  = k % FLEN;
            last = (pos == FLEN - 1);
            chk("sout_valid", 32'(sif.sout_valid), 32'd1);
            chk("sout",       32'(sif.sout),       32'(exp_q[k]));
            chk("frame_done", 32'(sif.frame_done), 32'(last));
            chk("din_ready",  32'(sif.din_ready),  32'(last));
            if (pos < W) got = {got[W-2:0], sif.sout};
            if (pos == W - 1) chk("word", 32'(got), 32'(words_q[k / FLEN]));
            if (last) begin
                if (nf < words_q.size()) begin
                    sif.din       = words_q[nf];
                    sif.din_valid = 1'b1;
                    nf++;
                end else begin
                    sif.din       = W'($urandom);
                    sif.din_valid = 1'b0;
                end
            end else begin
                sif.din       = rand_junk ? W'($urandom) : junk;
                sif.din_valid = 1'($urandom_range(0, 1));
            end
            tick();
        end
        idle_checks("end");
    endtask

    initial begin
        rst           = 1'b0;
        sif.din       = '0;
        sif.din_valid = 1'b0;

        // Reset state, before and after clock edges
        #3;
        chk("rst_sout",       32'(sif.sout),       32'd0);
        chk("rst_sout_valid", 32'(sif.sout_valid), 32'd0);
        chk("rst_frame_done", 32'(sif.frame_done), 32'd0);
        chk("rst_din_ready",  32'(sif.din_ready),  32'd0);
        sif.din_valid = 1'b1;
        tick();
        tick();
        chk("rst_clk_valid", 32'(sif.sout_valid), 32'd0);
        chk("rst_clk_ready", 32'(sif.din_ready),  32'd0);
        sif.din_valid = 1'b0;
        rst = 1'b1;
        #1;
        idle_checks("post_rst");

        // Single word
        words_q = '{8'h99};
        run_stream(1'b1, '0);

        // Back-to-back words
        words_q = '{8'hA5, 8'h3C};
        run_stream(1'b1, '0);

        // Parity-bearing pattern (plain word when parity is disabled)
        words_q = '{8'h07};
        run_stream(1'b1, '0);

        // Long idle with din wiggling
        sif.din_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sif.din = W'($urandom);
            tick();
            idle_checks("idle");
        end

        // din changes mid-frame must not disturb the frame in flight
        words_q = '{8'h0F};
        run_stream(1'b0, 8'hF0);

        // Reset asserted on the 4th bit of a frame
        sif.din       = 8'hFF;
        sif.din_valid = 1'b1;
        tick();
        sif.din_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_bit4_valid", 32'(sif.sout_valid), 32'd1);
        chk("mid_bit4_sout",  32'(sif.sout),       32'd1);
        rst = 1'b0;
        #1;
        chk("abort_sout",       32'(sif.sout),       32'd0);
        chk("abort_sout_valid", 32'(sif.sout_valid), 32'd0);
        chk("abort_frame_done", 32'(sif.frame_done), 32'd0);
        chk("abort_din_ready",  32'(sif.din_ready),  32'd0);
        tick();
        chk("abort_hold_valid", 32'(sif.sout_valid), 32'd0);
        rst = 1'b1;
        #1;
        words_q = '{8'h81};
        run_stream(1'b1, '0);

        // Random bursts with random idle gaps
        for (int r = 0; r < 10; r++) begin
            words_q.delete();
            for (int n = 0; n < int'($urandom_range(1, 4)); n++) words_q.push_back(W'($urandom));
            run_stream(1'b1, '0);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                sif.din = W'($urandom);
                tick();
                idle_checks("gap");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
